// File: rtl/adder_accumulator_pkg.sv
// Shared constants for the accumulator: default widths, FSM state encoding
// and the carry-out rule used by the adder.
package adder_accumulator_pkg;

  localparam int DEFAULT_NUM_BITS = 512;
  localparam int DEFAULT_CNT_W    = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } acc_state_t;

  // A carry leaves the top bit when both operand MSBs are set, or when one
  // is set and the MSB of the sum came out clear.
  function automatic logic add_carry(input logic a_msb,
                                     input logic b_msb,
                                     input logic sum_msb);
    return (a_msb & b_msb) | ((a_msb | b_msb) & ~sum_msb);
  endfunction

endpackage

// File: rtl/adder_accumulator_adder.sv
// Adder: wide wrap-around add of dd + aa with a carry-out flag derived from
// the operand and result MSBs.
module adder_accumulator_adder
  import adder_accumulator_pkg::*;
#(
  parameter int NUM_BITS = DEFAULT_NUM_BITS
) (
  input  logic [NUM_BITS-1:0] dd,
  input  logic [NUM_BITS-1:0] aa,
  output logic [NUM_BITS-1:0] sum,
  output logic                carry_out
);

  // Pure combinational add; the carry is rebuilt from the MSBs so no extra
  // result bit has to be carried through the wide adder.
  always_comb begin
    sum       = dd + aa;
    carry_out = add_carry(dd[NUM_BITS-1], aa[NUM_BITS-1], sum[NUM_BITS-1]);
  end

endmodule

// File: rtl/adder_accumulator.sv
// Accumulates a group of sum beats (terminated by in_last) into one total,
// counting beats and tracking a sticky overflow, then holds the result until
// downstream takes it.
module adder_accumulator
  import adder_accumulator_pkg::*;
#(
  parameter int NUM_BITS = DEFAULT_NUM_BITS,
  parameter int CNT_W    = DEFAULT_CNT_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [NUM_BITS-1:0] in_sum,
  input  logic                in_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [NUM_BITS-1:0] out_acc,
  output logic [CNT_W-1:0]    out_beats,
  output logic                out_overflow
);

  acc_state_t          state;
  acc_state_t          state_next;
  logic [NUM_BITS-1:0] acc;
  logic [CNT_W-1:0]    beats;
  logic                overflow;
  logic [NUM_BITS-1:0] add_sum;
  logic                add_carry_out;
  logic                accept;

  adder_accumulator_adder #(
    .NUM_BITS (NUM_BITS)
  ) u_adder (
    .dd        (acc),
    .aa        (in_sum),
    .sum       (add_sum),
    .carry_out (add_carry_out)
  );

  // Handshake and outputs are decoded from registered state only.
  assign in_ready     = (state == IDLE) || (state == ACCUM);
  assign out_valid    = (state == HOLD);
  assign accept       = in_valid && in_ready;
  assign out_acc      = acc;
  assign out_beats    = beats;
  assign out_overflow = overflow;

  // State register; reset abandons any group in progress or held result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: a last beat closes the group, HOLD leaves once consumed.
  always_comb begin
    state_next = state;
    case (state)
      IDLE, ACCUM: begin
        if (accept) begin
          state_next = in_last ? HOLD : ACCUM;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: the first beat of a group loads, later beats add with wrap,
  // saturating beat count and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      beats    <= '0;
      overflow <= 1'b0;
    end else if (accept) begin
      if (state == IDLE) begin
        acc      <= in_sum;
        beats    <= {{(CNT_W-1){1'b0}}, 1'b1};
        overflow <= 1'b0;
      end else begin
        acc      <= add_sum;
        overflow <= overflow | add_carry_out;
        if (beats != {CNT_W{1'b1}}) begin
          beats <= beats + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_adder_accumulator.sv
// Scoreboard bench for adder_accumulator: the driver computes each group's
// expected result with plain wide arithmetic and queues it; a monitor pops
// and compares whenever the DUT presents a result.
module tb_adder_accumulator;

  localparam int NUM_BITS  = 512;
  localparam int CNT_W     = 2;
  localparam int MAX_BEATS = (1 << CNT_W) - 1;

  typedef struct {
    logic [NUM_BITS-1:0] acc;
    int                  beats;
    logic                ovf;
  } result_t;

  logic                clk;
  logic                rst;
  logic                in_valid;
  logic                in_ready;
  logic [NUM_BITS-1:0] in_sum;
  logic                in_last;
  logic                out_valid;
  logic                out_ready;
  logic [NUM_BITS-1:0] out_acc;
  logic [CNT_W-1:0]    out_beats;
  logic                out_overflow;

  int compared   = 0;
  int mismatched = 0;

  result_t             exp_q[$];
  result_t             cur;
  logic [NUM_BITS-1:0] model_acc;
  int                  model_beats = 0;
  logic                model_ovf;

  bit check_en = 0;
  bit holding  = 0;
  bit pending  = 0;
  bit hold_off = 0;

  adder_accumulator #(
    .NUM_BITS (NUM_BITS),
    .CNT_W    (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_sum       (in_sum),
    .in_last      (in_last),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_acc      (out_acc),
    .out_beats    (out_beats),
    .out_overflow (out_overflow)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name,
                             input logic [NUM_BITS-1:0] actual,
                             input logic [NUM_BITS-1:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  function automatic logic [NUM_BITS-1:0] randData();
    logic [NUM_BITS-1:0] r;
    int mode;
    mode = $urandom_range(0, 3);
    for (int i = 0; i < NUM_BITS / 32; i++) r[i*32 +: 32] = $urandom;
    if (mode == 0) r = NUM_BITS'($urandom_range(0, 255));
    else if (mode == 1) r = {NUM_BITS{1'b1}} - NUM_BITS'($urandom_range(0, 255));
    return r;
  endfunction

  // Issues one beat (called just after a rising edge) and waits until it is
  // taken; the reference total is built with a one-bit-wider add.
  task automatic applyStimulus(input logic [NUM_BITS-1:0] data, input logic last);
    logic [NUM_BITS:0] wide;
    result_t r;
    bit ok;
    int waited;
    if (model_beats == 0) begin
      model_acc = data;
      model_ovf = 1'b0;
    end else begin
      wide      = {1'b0, model_acc} + {1'b0, data};
      model_acc = wide[NUM_BITS-1:0];
      model_ovf = model_ovf | wide[NUM_BITS];
    end
    model_beats++;
    if (last) begin
      r.acc   = model_acc;
      r.beats = (model_beats > MAX_BEATS) ? MAX_BEATS : model_beats;
      r.ovf   = model_ovf;
      exp_q.push_back(r);
      model_beats = 0;
    end
    in_valid = 1'b1;
    in_sum   = data;
    in_last  = last;
    waited   = 0;
    do begin
      ok = in_ready;
      @(posedge clk);
      #1;
      waited++;
    end while (!ok && waited < 200);
    if (!ok) checkOutput("accept_timeout", '0, 1);
    in_valid = 1'b0;
    in_sum   = randData();
    in_last  = 1'($urandom_range(0, 1));
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      in_sum  = randData();
      in_last = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyReset();
    in_valid = 1'b0;
    rst      = 1'b1;
    @(posedge clk);
    #1;
    rst         = 1'b0;
    model_beats = 0;
  endtask

  // Downstream ready: random acceptance unless the bench forces a stall.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      out_ready = hold_off ? 1'b0 : 1'($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: tracks when a result must be presented, pops the expected entry
  // when it first appears and re-checks it every cycle it is held.
  always @(negedge clk) begin
    bit exp_valid;
    if (check_en) begin
      exp_valid = holding || pending;
      checkOutput("out_valid", out_valid, exp_valid);
      checkOutput("in_ready", in_ready, !exp_valid);
      if (out_valid) begin
        if (!holding) begin
          if (exp_q.size() == 0) begin
            checkOutput("unexpected_result", '0, 1);
            cur.acc = 'x; cur.beats = 0; cur.ovf = 1'bx;
          end else begin
            cur = exp_q.pop_front();
          end
        end
        checkOutput("out_acc", out_acc, cur.acc);
        checkOutput("out_beats", out_beats, cur.beats);
        checkOutput("out_overflow", out_overflow, cur.ovf);
      end
      holding = exp_valid && !out_ready;
      pending = !exp_valid && in_valid && in_last;
      if (rst) begin
        holding = 0;
        pending = 0;
      end
    end
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    mismatched++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Directed scenarios followed by random groups.
  initial begin
    int waited;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_sum   = '0;
    in_last  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_acc", out_acc, '0);
    checkOutput("reset_beats", out_beats, '0);
    checkOutput("reset_ovf", out_overflow, '0);
    checkOutput("reset_valid", out_valid, '0);
    checkOutput("reset_ready", in_ready, 1);
    rst      = 1'b0;
    check_en = 1;

    applyStimulus(NUM_BITS'(32'h82), 1'b1);
    idleCycles(3);

    applyStimulus(NUM_BITS'(1), 1'b0);
    applyStimulus(NUM_BITS'(2), 1'b0);
    applyStimulus(NUM_BITS'(3), 1'b1);
    idleCycles(3);

    applyStimulus({NUM_BITS{1'b1}}, 1'b0);
    applyStimulus(NUM_BITS'(2), 1'b1);
    applyStimulus(NUM_BITS'(5), 1'b1);
    idleCycles(3);

    for (int i = 0; i < 5; i++) applyStimulus(NUM_BITS'(1), i == 4);
    idleCycles(3);

    hold_off = 1;
    applyStimulus(NUM_BITS'(32'h11), 1'b1);
    fork
      applyStimulus(NUM_BITS'(32'h22), 1'b1);
      begin
        repeat (5) @(posedge clk);
        #1;
        hold_off = 0;
      end
    join
    idleCycles(4);

    applyStimulus(NUM_BITS'(9), 1'b0);
    applyStimulus(NUM_BITS'(4), 1'b0);
    applyReset();
    checkOutput("mid_reset_valid", out_valid, '0);
    checkOutput("mid_reset_ready", in_ready, 1);
    checkOutput("mid_reset_acc", out_acc, '0);
    applyStimulus(NUM_BITS'(7), 1'b1);
    idleCycles(3);

    hold_off = 1;
    applyStimulus(randData(), 1'b1);
    idleCycles(2);
    applyReset();
    checkOutput("hold_reset_valid", out_valid, '0);
    checkOutput("hold_reset_beats", out_beats, '0);
    checkOutput("hold_reset_ovf", out_overflow, '0);
    hold_off = 0;
    idleCycles(2);

    for (int g = 0; g < 40; g++) begin
      int n;
      n = $urandom_range(1, 6);
      for (int b = 0; b < n; b++) begin
        applyStimulus(randData(), b == n - 1);
        if ($urandom_range(0, 3) == 0) idleCycles($urandom_range(1, 3));
      end
    end

    waited = 0;
    while ((exp_q.size() != 0 || out_valid) && waited < 300) begin
      @(posedge clk);
      #1;
      waited++;
    end
    checkOutput("drain_queue", exp_q.size(), 0);
    checkOutput("drain_valid", out_valid, '0);
    idleCycles(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/adder_accumulator.md
ADDER_ACCUMULATOR -- requirements
Module: adder_accumulator

Interface
REQ-001 SHALL have parameter NUM_BITS, default 512, operand/accumulator width in bits.
REQ-002 SHALL have parameter CNT_W, default 8, beat-counter width in bits.
REQ-003 SHALL use one clock and synchronous, active-high reset: clk input 1 rising-edge clock.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 in_valid  input  1  in_sum beat valid.
REQ-006 in_ready  output  1  block accepts a beat this cycle.
REQ-007 in_sum  input  NUM_BITS  sum word from upstream Adder.
REQ-008 in_last  input  1  final beat of the current accumulation.
REQ-009 out_valid  output  1  accumulated result available.
REQ-010 out_ready  input  1  downstream accepts the result.
REQ-011 out_acc  output  NUM_BITS  accumulated total, modulo 2^NUM_BITS.
REQ-012 out_beats  output  CNT_W  number of beats accumulated, saturating.
REQ-013 out_overflow  output  1  sticky flag: carry out of bit NUM_BITS-1 occurred during the group.

Function
REQ-014 SHALL implement states IDLE, ACCUM, HOLD; a beat is accepted when in_valid && in_ready.
REQ-015 in_ready SHALL be 1 in IDLE and ACCUM, 0 in HOLD; out_valid SHALL be 1 only in HOLD.
REQ-016 IDLE, beat accepted: acc <= in_sum, beats <= 1, overflow <= 0; next state HOLD if in_last else ACCUM.
REQ-017 ACCUM, beat accepted: acc <= acc + in_sum (wrap), overflow <= overflow | carry_out, beats <= beats+1 saturating at 2^CNT_W-1; next HOLD if in_last else ACCUM.
REQ-018 carry_out SHALL be (a_msb & b_msb) | ((a_msb | b_msb) & ~sum_msb) of the NUM_BITS-bit add.
REQ-019 IDLE/ACCUM with no accepted beat: all registers hold; state unchanged.
REQ-020 HOLD: out_acc, out_beats, out_overflow stable while out_valid=1 && out_ready=0.
REQ-021 HOLD, out_ready=1: result consumed, next state IDLE; in_valid ignored that cycle (one-cycle bubble).
REQ-022 out_valid SHALL assert the cycle after the in_last beat is accepted (latency 1).
REQ-023 All outputs SHALL be registered or decoded from registered state only; no combinational in-to-out path.
REQ-024 in_sum/in_last when in_valid=0 SHALL have no effect.

Reset
REQ-025 rst=1 SHALL force state IDLE, acc=0, out_beats=0, out_overflow=0, out_valid=0, in_ready=1 at the next clk edge.
REQ-026 rst SHALL take priority over any handshake in the same cycle; reset mid-group or in HOLD discards the partial/held result.

Structure
REQ-027 State encodings (IDLE=2'd0, ACCUM=2'd1, HOLD=2'd2) and default NUM_BITS SHALL live in the shared MPU constants header.
REQ-028 The add SHALL instantiate the existing Adder as its sole sub-module (dd=acc, aa=in_sum), parameterised with NUM_BITS.

Verification
REQ-029 Single beat in_sum=512'h82, in_last=1 -> next cycle out_valid=1, out_acc=512'h82, out_beats=1, out_overflow=0.
REQ-030 Three beats 1, 2, 3 (last on third) -> out_acc=6, out_beats=3; out_valid rises exactly one cycle after third beat.
REQ-031 Beats {512{1'b1}} then 512'h2 (last) -> out_acc=1, out_overflow=1; next group starting 512'h5 single-beat -> out_overflow=0.
REQ-032 HOLD with out_ready=0 for 5 cycles while in_valid=1 -> in_ready=0, outputs unchanged, no beat consumed; out_ready=1 -> IDLE next cycle.
REQ-033 CNT_W=2, five beats of 1 -> out_acc=5, out_beats=3 (saturated).
REQ-034 rst asserted after two beats of a group -> next cycle out_valid=0, in_ready=1; new single beat 512'h7 -> out_acc=7, out_beats=1.
